// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-back write-allocate cache controller
module cache_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int TAG_WIDTH  = 32 - ADDR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic [ADDR_WIDTH-1:0] dm_r_addr,
  output logic                  dm_r_en,
  input  logic [DATA_WIDTH-1:0] dm_r_data,
  output logic [ADDR_WIDTH-1:0] dm_w_addr,
  output logic [DATA_WIDTH-1:0] dm_w_data,
  output logic                  dm_w_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int LINES = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_t;

  state_t state;

  // tag storage is a plain synchronous RAM; valid/dirty are flops so reset clears them
  logic [TAG_WIDTH-1:0]  tag_mem [LINES];
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;

  // latched request; byte offset bits are never needed
  logic [31:2]           req_addr;
  logic                  req_we;
  logic [31:0]           req_wdata;

  logic [1:0]            req_word;
  logic [ADDR_WIDTH-1:0] req_index;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  accept;
  logic                  hit;
  logic                  ack_seen;
  logic [DATA_WIDTH-1:0] fill_line;
  logic                  addr_unused;

  assign req_word  = req_addr[3:2];
  assign req_index = req_addr[ADDR_WIDTH+3:4];
  assign req_tag   = req_addr[31:ADDR_WIDTH+4];

  assign addr_unused = ^cpu_addr[1:0];

  // cpu_ready is still high in the cycle after completion while the CPU releases
  // cpu_req, so a request is only taken once that pulse has gone
  assign accept = (state == IDLE) && cpu_req && !cpu_ready && !rst;

  // the array read is issued in the accept cycle so line and tag arrive in LOOKUP
  assign dm_r_en   = accept;
  assign dm_r_addr = accept ? cpu_addr[ADDR_WIDTH+3:4] : '0;

  assign hit      = valid[req_index] && (tag_q == req_tag);
  assign ack_seen = mem_ack && mem_req;

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] line,
    input logic [1:0]            word,
    input logic [31:0]           wd
  );
    logic [DATA_WIDTH-1:0] r;
    r = line;
    r[{word, 5'b0} +: 32] = wd;
    return r;
  endfunction

  assign fill_line = req_we ? merge_word(mem_rdata, req_word, req_wdata) : mem_rdata;

  // tag RAM: read alongside the data array, written when a fill completes
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q <= tag_mem[cpu_addr[ADDR_WIDTH+3:4]];
    end
    if (state == FILL && ack_seen) begin
      tag_mem[req_index] <= req_tag;
    end
  end

  // controller FSM with registered CPU, array-write and memory outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      dm_w_addr <= '0;
      dm_w_data <= '0;
      dm_w_en   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dm_w_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_addr  <= cpu_addr[31:2];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we) begin
              dm_w_en          <= 1'b1;
              dm_w_addr        <= req_index;
              dm_w_data        <= merge_word(dm_r_data, req_word, req_wdata);
              dirty[req_index] <= 1'b1;
            end else begin
              cpu_rdata <= dm_r_data[{req_word, 5'b0} +: 32];
            end
            cpu_ready <= 1'b1;
            hit_cnt   <= hit_cnt + 32'd1;
            state     <= IDLE;
          end else if (valid[req_index] && dirty[req_index]) begin
            // victim line is captured now; the array copy may be overwritten later
            mem_wdata <= dm_r_data;
            mem_addr  <= {tag_q, req_index, 4'b0};
            mem_we    <= 1'b1;
            mem_req   <= 1'b1;
            state     <= WB;
          end else begin
            mem_addr <= {req_tag, req_index, 4'b0};
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            state    <= FILL;
          end
        end
        WB: begin
          if (ack_seen) begin
            // request stays up and turns straight into the line fetch
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_index, 4'b0};
            state    <= FILL;
          end
        end
        FILL: begin
          if (ack_seen) begin
            mem_req          <= 1'b0;
            dm_w_en          <= 1'b1;
            dm_w_addr        <= req_index;
            dm_w_data        <= fill_line;
            valid[req_index] <= 1'b1;
            dirty[req_index] <= req_we;
            cpu_rdata        <= fill_line[{req_word, 5'b0} +: 32];
            state            <= RESP;
          end
        end
        RESP: begin
          cpu_ready <= 1'b1;
          miss_cnt  <= miss_cnt + 32'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - randomized self-checking bench for cache_ctrl
`timescale 1ns/1ps
module tb_cache_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic [7:0]    dm_r_addr;
  logic          dm_r_en;
  logic [127:0]  dm_r_data = '0;
  logic [7:0]    dm_w_addr;
  logic [127:0]  dm_w_data;
  logic          dm_w_en;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dm_r_addr(dm_r_addr), .dm_r_en(dm_r_en), .dm_r_data(dm_r_data),
    .dm_w_addr(dm_w_addr), .dm_w_data(dm_w_data), .dm_w_en(dm_w_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // cache_mem stand-in: registered read with write forwarding
  logic [127:0] dmem [256];
  always @(posedge clk) begin
    if (dm_w_en) dmem[dm_w_addr] <= dm_w_data;
    if (dm_r_en) dm_r_data <= (dm_w_en && dm_w_addr == dm_r_addr) ? dm_w_data : dmem[dm_r_addr];
  end

  // initial main-memory contents
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [127:0] init_line(input logic [31:0] la);
    if (la == 32'h0000_1230) return 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;
    return {init_word(la + 32'd12), init_word(la + 32'd8), init_word(la + 32'd4), init_word(la)};
  endfunction

  logic [127:0] env_mem [logic [31:0]];
  logic [127:0] ref_mem [logic [31:0]];

  function automatic logic [127:0] env_get(input logic [31:0] la);
    if (env_mem.exists(la)) return env_mem[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] ref_get(input logic [31:0] la);
    if (ref_mem.exists(la)) return ref_mem[la];
    return init_line(la);
  endfunction

  // reference cache: per-index tag/valid/dirty and line contents
  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } memop_t;

  memop_t       exp_mem [$];
  logic         m_valid [256];
  logic         m_dirty [256];
  logic [19:0]  m_tag [256];
  logic [127:0] m_line [256];
  int           exp_hits;
  int           exp_misses;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
    exp_mem.delete();
  endtask

  task automatic model_predict(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               output bit hit, output logic [31:0] rd, output int n_mem);
    int idx;
    int w;
    logic [19:0] tg;
    logic [31:0] la;
    logic [31:0] va;
    logic [127:0] ln;
    idx = int'(addr[11:4]);
    w = int'(addr[3:2]);
    tg = addr[31:12];
    la = {addr[31:4], 4'h0};
    n_mem = 0;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      exp_hits++;
    end else begin
      exp_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        va = {m_tag[idx], addr[11:4], 4'h0};
        exp_mem.push_back('{1'b1, va, m_line[idx]});
        ref_mem[va] = m_line[idx];
        n_mem++;
      end
      exp_mem.push_back('{1'b0, la, 128'h0});
      n_mem++;
      m_line[idx] = ref_get(la);
      m_tag[idx] = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    ln = m_line[idx];
    if (we) begin
      ln[w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
    m_line[idx] = ln;
    rd = ln[w*32 +: 32];
  endtask

  // memory responder: checks each request against the model, then acks after a delay
  int           mem_lat_force = -1;
  bit           spurious_en = 1'b0;
  bit           mem_busy = 1'b0;
  int           mem_wait = 0;
  int           mem_reqs_seen = 0;
  logic [31:0]  hold_addr;
  logic         hold_we;
  logic [31:0]  seen_addr [$];
  logic         seen_we [$];
  logic [127:0] seen_wdata [$];

  always @(negedge clk) begin
    memop_t e;
    mem_ack = 1'b0;
    if (rst) begin
      mem_busy = 1'b0;
    end else if (mem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_reqs_seen++;
        hold_addr = mem_addr;
        hold_we = mem_we;
        seen_addr.push_back(mem_addr);
        seen_we.push_back(mem_we);
        seen_wdata.push_back(mem_wdata);
        if (exp_mem.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL mem_unexpected: got request addr %0h, required none", mem_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
        end
        mem_wait = (mem_lat_force >= 0) ? mem_lat_force : int'($urandom_range(0, 4));
      end else begin
        chk("mem_hold_addr", mem_addr, hold_addr);
        chk("mem_hold_we", mem_we, hold_we);
      end
      if (mem_wait == 0) begin
        if (hold_we) env_mem[hold_addr] = mem_wdata;
        else mem_rdata = env_get(hold_addr);
        mem_ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_wait--;
      end
    end else if (spurious_en && $urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // single-cycle pulse checks
  logic prev_ready = 1'b0;
  logic prev_wen = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_pulse", cpu_ready && prev_ready, 1'b0);
      chk("dm_w_en_pulse", dm_w_en && prev_wen, 1'b0);
    end
    prev_ready = cpu_ready;
    prev_wen = dm_w_en;
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, output logic [31:0] rd_o, output int cyc);
    bit hit;
    logic [31:0] exp_rd;
    int n_mem;
    int seen0;
    model_predict(we, addr, wd, hit, exp_rd, n_mem);
    mem_lat_force = lat;
    @(negedge clk);
    seen0 = mem_reqs_seen;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_ready && cyc < 400);
    if (!cpu_ready) begin
      nchecks++;
      nerr++;
      $display("FAIL ready_timeout: addr %0h got no cpu_ready, required one within 400 cycles", addr);
    end else begin
      if (!we) chk("cpu_rdata", cpu_rdata, exp_rd);
      chk("hit_cnt", hit_cnt, exp_hits);
      chk("miss_cnt", miss_cnt, exp_misses);
      chk("mem_op_count", mem_reqs_seen - seen0, n_mem);
      if (hit) chk("hit_latency", cyc, 2);
    end
    rd_o = cpu_rdata;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic clear_log();
    seen_addr.delete();
    seen_we.delete();
    seen_wdata.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rd;
    logic [127:0] wb_line;
    logic [7:0]   ri;
    logic [19:0]  rt;
    int           cyc;
    int           guard;
    bit           h6;
    logic [31:0]  r6;
    int           n6;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_dm_w_en", dm_w_en, 1'b0);
    chk("rst_dm_r_en", dm_r_en, 1'b0);
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
    rst = 1'b0;

    // cold load: word 1 of the line is bits [63:32]
    clear_log();
    do_req(1'b0, 32'h0000_1234, 32'h0, 3, rd, cyc);
    chk("t1_nreq", seen_addr.size(), 1);
    chk("t1_fetch_we", seen_we[0], 1'b0);
    chk("t1_fetch_addr", seen_addr[0], 32'h0000_1230);
    chk("t1_rdata", rd, 32'h9999_8888);
    chk("t1_miss_cnt", miss_cnt, 32'd1);

    clear_log();
    do_req(1'b0, 32'h0000_1234, 32'h0, -1, rd, cyc);
    chk("t2_latency", cyc, 2);
    chk("t2_nreq", seen_addr.size(), 0);
    chk("t2_rdata", rd, 32'h9999_8888);
    chk("t2_hit_cnt", hit_cnt, 32'd1);

    do_req(1'b1, 32'h0000_1238, 32'hCAFE_F00D, -1, rd, cyc);
    do_req(1'b0, 32'h0000_1238, 32'h0, -1, rd, cyc);
    chk("t3_dirty", dut.dirty[8'h23], 1'b1);
    chk("t3_rdata", rd, 32'hCAFE_F00D);

    clear_log();
    do_req(1'b0, 32'h0000_2234, 32'h0, -1, rd, cyc);
    chk("t4_nreq", seen_addr.size(), 2);
    chk("t4_wb_we", seen_we[0], 1'b1);
    chk("t4_wb_addr", seen_addr[0], 32'h0000_1230);
    wb_line = seen_wdata[0];
    chk("t4_wb_word2", wb_line[95:64], 32'hCAFE_F00D);
    chk("t4_fetch_we", seen_we[1], 1'b0);
    chk("t4_fetch_addr", seen_addr[1], 32'h0000_2230);
    chk("t4_miss_cnt", miss_cnt, 32'd2);

    do_req(1'b0, 32'h0000_3234, 32'h0, 20, rd, cyc);
    chk("t5_long_wait", cyc >= 22, 1'b1);
    chk("t5_miss_cnt", miss_cnt, 32'd3);

    // reset while the fetch is outstanding
    model_predict(1'b0, 32'h0000_1234, 32'h0, h6, r6, n6);
    mem_lat_force = 10;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h0000_1234;
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_fill_started", mem_req, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_mem_req_drop", mem_req, 1'b0);
    chk("t6_ready", cpu_ready, 1'b0);
    chk("t6_miss_cnt_rst", miss_cnt, 32'h0);
    repeat (2) @(negedge clk);
    cpu_req = 1'b0;
    rst = 1'b0;
    model_reset();
    clear_log();
    do_req(1'b0, 32'h0000_1234, 32'h0, -1, rd, cyc);
    chk("t6_nreq", seen_addr.size(), 1);
    chk("t6_refetch_addr", seen_addr[0], 32'h0000_1230);
    chk("t6_miss_cnt", miss_cnt, 32'd1);
    chk("t6_hit_cnt", hit_cnt, 32'd0);

    // random traffic over a few conflicting indices and tags
    spurious_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: ri = 8'h23;
        1: ri = 8'h10;
        2: ri = 8'hFF;
        default: ri = 8'h00;
      endcase
      rt = 20'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(($urandom_range(0, 9) < 4), {rt, ri, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
             $urandom, -1, rd, cyc);
    end
    spurious_en = 1'b0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
